// File: rtl/alu_sequencer_if.sv
// ALU sequencer shared op type and port bundle.
// ALU_SEQ_SCALAR_EN adds cmd_scalar_i (broadcast operand 1).
package alu_seq_pkg;
  typedef enum logic [2:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHIFT_LEFT,
    ALU_SHIFT_RIGHT
  } alu_op_t;
endpackage

interface alu_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int VLMAX = 64
);
  import alu_seq_pkg::*;
  localparam int VLW = $clog2(VLMAX + 1);

  logic            cmd_valid_i;
  logic            cmd_ready_o;
  alu_op_t         cmd_op_i;
  logic [VLW-1:0]  cmd_vl_i;
`ifdef ALU_SEQ_SCALAR_EN
  logic [XLEN-1:0] cmd_scalar_i;
`endif

  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_op0_i;
  logic [XLEN-1:0] in_op1_i;

  alu_op_t                  alu_op_o;
  logic [1:0][XLEN-1:0]     alu_operand_o;
  logic [XLEN-1:0]          alu_result_i;

  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_data_o;
  logic [VLW-1:0]  out_idx_o;
  logic            out_last_o;

  logic            done_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_vl_i,
`ifdef ALU_SEQ_SCALAR_EN
    input  cmd_scalar_i,
`endif
    output cmd_ready_o,
    input  in_valid_i, in_op0_i, in_op1_i,
    output in_ready_o,
    output alu_op_o, alu_operand_o,
    input  alu_result_i,
    output out_valid_o, out_data_o,
    output out_idx_o, out_last_o,
    input  out_ready_i,
    output done_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_vl_i,
`ifdef ALU_SEQ_SCALAR_EN
    output cmd_scalar_i,
`endif
    input  cmd_ready_o,
    output in_valid_i, in_op0_i, in_op1_i,
    input  in_ready_o,
    input  alu_op_o, alu_operand_o,
    output alu_result_i,
    input  out_valid_o, out_data_o,
    input  out_idx_o, out_last_o,
    output out_ready_i,
    input  done_o
  );
endinterface

// File: rtl/alu_sequencer.sv
// Streams vl operand pairs through a shared ALU, one result per cycle.
// Optional ALU_SEQ_SCALAR_EN: operand 1 comes from a latched scalar.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int VLMAX = 64
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         flush_i,
  alu_sequencer_if.slave bus
);
  localparam int VLW = $clog2(VLMAX + 1);
  localparam logic [VLW-1:0] VL_CAP = VLW'(VLMAX);
  localparam logic [VLW-1:0] ONE = VLW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  alu_op_t         op_q, op_d;
  logic [VLW-1:0]  vl_q, vl_d;
  logic [VLW-1:0]  cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [VLW-1:0]  idx_q, idx_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] opnd1;

  logic            cmd_hs;
  logic            in_hs;
  logic            out_hs;
  logic            is_last;
  logic [VLW-1:0]  vl_clip;

`ifdef ALU_SEQ_SCALAR_EN
  logic [XLEN-1:0] scalar_q, scalar_d;
  assign opnd1 = scalar_q;
`else
  assign opnd1 = bus.in_op1_i;
`endif

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.in_ready_o  = (state_q == S_RUN)
                         & (~vld_q | bus.out_ready_i);

  assign cmd_hs  = bus.cmd_valid_i & bus.cmd_ready_o;
  assign in_hs   = bus.in_valid_i & bus.in_ready_o;
  assign out_hs  = vld_q & bus.out_ready_i;
  assign is_last = (cnt_q == vl_q - ONE);
  assign vl_clip = (bus.cmd_vl_i > VL_CAP) ? VL_CAP
                                           : bus.cmd_vl_i;

  assign bus.out_valid_o = vld_q;
  assign bus.out_data_o  = data_q;
  assign bus.out_idx_o   = idx_q;
  assign bus.out_last_o  = last_q;
  assign bus.done_o      = done_q;

  // Drive the shared ALU only while elements are flowing.
  always_comb begin
    bus.alu_op_o      = ALU_NONE;
    bus.alu_operand_o = '0;
    if (state_q == S_RUN) begin
      bus.alu_op_o         = op_q;
      bus.alu_operand_o[0] = bus.in_op0_i;
      bus.alu_operand_o[1] = opnd1;
    end
  end

  // Next state, element counter and result register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vl_d    = vl_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef ALU_SEQ_SCALAR_EN
    scalar_d = scalar_q;
`endif

    if (out_hs) begin
      vld_d = 1'b0;
    end
    if (in_hs) begin
      vld_d  = 1'b1;
      data_d = bus.alu_result_i;
      idx_d  = cnt_q;
      last_d = is_last;
      cnt_d  = cnt_q + ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          op_d  = bus.cmd_op_i;
          vl_d  = vl_clip;
          cnt_d = '0;
`ifdef ALU_SEQ_SCALAR_EN
          scalar_d = bus.cmd_scalar_i;
`endif
          if (vl_clip == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (in_hs && is_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs && last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= ALU_NONE;
      vl_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_SEQ_SCALAR_EN
      scalar_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vl_q    <= vl_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef ALU_SEQ_SCALAR_EN
      scalar_q <= scalar_d;
`endif
    end
  end
endmodule
